// File: rtl/trace_pkg.sv
// Shared definitions for the commit trace buffer: state encoding, flag bits and entry layout.
// Entry layout (LSB first): flags, pc, instruction, ALU result, mem address, store data, [timestamp].
package trace_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        POST   = 2'd2,
        FROZEN = 2'd3
    } traceState_e;

    localparam int FLAGS_W        = 4;
    localparam int FLAG_TRIG      = 3;
    localparam int FLAG_REG_WRITE = 2;
    localparam int FLAG_MEM_READ  = 1;
    localparam int FLAG_MEM_WRITE = 0;

    localparam int FIELD_PC    = 0;
    localparam int FIELD_INSTR = 1;
    localparam int FIELD_ALU   = 2;
    localparam int FIELD_ADDR  = 3;
    localparam int FIELD_WDATA = 4;
    localparam int NUM_FIELDS  = 5;

    // Bit offset of an XLEN-wide field; the timestamp sits at index NUM_FIELDS.
    function automatic int fieldLsb(input int field, input int xlen);
        return FLAGS_W + field * xlen;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace storage: DEPTH x WIDTH array with one write port and one registered read port.
// The array itself is not reset; only the read register is.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 164
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wrEn,
    input  logic [$clog2(DEPTH)-1:0] wrAddr,
    input  logic [WIDTH-1:0]         wrData,
    input  logic                     rdEn,
    input  logic [$clog2(DEPTH)-1:0] rdAddr,
    output logic [WIDTH-1:0]         rdData
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) mem[wrAddr] <= wrData;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      rdData <= '0;
        else if (rdEn) rdData <= mem[rdAddr];
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit trace recorder: circular capture, PC trigger with post-trigger count, freeze, oldest-first readout.
// Optional per-entry timestamp when TRACE_TIMESTAMP_EN is defined.
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 16,
    parameter int POST_W = 8,
    parameter int TS_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cap_valid,
    input  logic [XLEN-1:0]            pc,
    input  logic [XLEN-1:0]            instruction,
    input  logic                       RegWrite,
    input  logic                       MemRead,
    input  logic                       MemWrite,
    input  logic [XLEN-1:0]            ALU_Result,
    input  logic [XLEN-1:0]            MemAddr,
    input  logic [XLEN-1:0]            MemWrite_Data,
    input  logic                       arm,
    input  logic                       stop_on_full,
    input  logic                       trig_en,
    input  logic [XLEN-1:0]            trig_pc,
    input  logic [POST_W-1:0]          post_cnt,
    input  logic                       rd_req,
    output logic                       rd_valid,
    output logic [XLEN-1:0]            rd_pc,
    output logic [XLEN-1:0]            rd_instr,
    output logic [3:0]                 rd_flags,
    output logic [XLEN-1:0]            rd_alu,
    output logic [XLEN-1:0]            rd_addr,
    output logic [XLEN-1:0]            rd_wdata,
    output logic [TS_W-1:0]            rd_ts,
    output logic [1:0]                 state_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow
);

    localparam int AW       = $clog2(DEPTH);
    localparam int CW       = AW + 1;
    localparam int PcLsb    = fieldLsb(FIELD_PC, XLEN);
    localparam int InstrLsb = fieldLsb(FIELD_INSTR, XLEN);
    localparam int AluLsb   = fieldLsb(FIELD_ALU, XLEN);
    localparam int AddrLsb  = fieldLsb(FIELD_ADDR, XLEN);
    localparam int WdataLsb = fieldLsb(FIELD_WDATA, XLEN);
`ifdef TRACE_TIMESTAMP_EN
    localparam int TsLsb    = fieldLsb(NUM_FIELDS, XLEN);
    localparam int EntryW   = TsLsb + TS_W;
`else
    localparam int EntryW   = fieldLsb(NUM_FIELDS, XLEN);
`endif

    traceState_e       state;
    logic [AW-1:0]     wrPtr;
    logic [CW-1:0]     count;
    logic [POST_W-1:0] postLeft;
    logic              ovf;
    logic              rdValid;

    logic              full;
    logic              trigHit;
    logic              dropFull;
    logic              doWrite;
    logic              rdAccept;
    logic [AW-1:0]     rdIdx;
    logic [EntryW-1:0] wrData;
    logic [EntryW-1:0] rdData;

    assign full     = (count == CW'(DEPTH));
    assign trigHit  = trig_en && (pc == trig_pc);
    assign dropFull = stop_on_full && full;
    assign doWrite  = !arm && cap_valid
                    && (((state == ARMED) && !dropFull) || (state == POST));
    assign rdAccept = !arm && rd_req && (state == FROZEN) && (count != '0);
    // When full, count[AW-1:0] is 0 and the oldest entry sits at wrPtr.
    assign rdIdx    = wrPtr - count[AW-1:0];

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] tsCnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tsCnt <= '0;
        else      tsCnt <= tsCnt + 1'b1;
    end
`endif

    always_comb begin
        wrData                       = '0;
        wrData[FLAG_TRIG]            = (state == ARMED) && trigHit;
        wrData[FLAG_REG_WRITE]       = RegWrite;
        wrData[FLAG_MEM_READ]        = MemRead;
        wrData[FLAG_MEM_WRITE]       = MemWrite;
        wrData[PcLsb    +: XLEN]     = pc;
        wrData[InstrLsb +: XLEN]     = instruction;
        wrData[AluLsb   +: XLEN]     = ALU_Result;
        wrData[AddrLsb  +: XLEN]     = MemAddr;
        wrData[WdataLsb +: XLEN]     = MemWrite_Data;
`ifdef TRACE_TIMESTAMP_EN
        wrData[TsLsb    +: TS_W]     = tsCnt;
`endif
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EntryW)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .wrEn   (doWrite),
        .wrAddr (wrPtr),
        .wrData (wrData),
        .rdEn   (rdAccept),
        .rdAddr (rdIdx),
        .rdData (rdData)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wrPtr    <= '0;
            count    <= '0;
            postLeft <= '0;
            ovf      <= 1'b0;
            rdValid  <= 1'b0;
        end else if (arm) begin
            state    <= ARMED;
            wrPtr    <= '0;
            count    <= '0;
            postLeft <= '0;
            ovf      <= 1'b0;
            rdValid  <= 1'b0;
        end else begin
            rdValid <= rdAccept;
            if (rdAccept) count <= count - 1'b1;
            if (doWrite) begin
                wrPtr <= wrPtr + 1'b1;
                if (full) ovf   <= 1'b1;
                else      count <= count + 1'b1;
            end
            case (state)
                ARMED: begin
                    if (cap_valid) begin
                        if (dropFull) begin
                            state <= FROZEN;
                        end else if (trigHit) begin
                            if (post_cnt == '0) begin
                                state <= FROZEN;
                            end else begin
                                postLeft <= post_cnt;
                                state    <= POST;
                            end
                        end
                    end
                end
                POST: begin
                    if (cap_valid) begin
                        postLeft <= postLeft - 1'b1;
                        if (postLeft == POST_W'(1)) state <= FROZEN;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_valid = rdValid;
    assign rd_flags = rdData[FLAGS_W-1:0];
    assign rd_pc    = rdData[PcLsb    +: XLEN];
    assign rd_instr = rdData[InstrLsb +: XLEN];
    assign rd_alu   = rdData[AluLsb   +: XLEN];
    assign rd_addr  = rdData[AddrLsb  +: XLEN];
    assign rd_wdata = rdData[WdataLsb +: XLEN];
`ifdef TRACE_TIMESTAMP_EN
    assign rd_ts    = rdData[TsLsb +: TS_W];
`else
    assign rd_ts    = '0;
`endif
    assign state_o  = state;
    assign count_o  = count;
    assign overflow = ovf;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: capture/trigger vector tables plus hand-written readout,
// arm-priority, async-reset and (with TRACE_TIMESTAMP_EN) timestamp sequences.
module tb_commit_trace_buffer;

    localparam int XLEN   = 32;
    localparam int DEPTH  = 16;
    localparam int POST_W = 8;
    localparam int TS_W   = 16;

    logic              clk;
    logic              rst;
    logic              cap_valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   instruction;
    logic              RegWrite;
    logic              MemRead;
    logic              MemWrite;
    logic [XLEN-1:0]   ALU_Result;
    logic [XLEN-1:0]   MemAddr;
    logic [XLEN-1:0]   MemWrite_Data;
    logic              arm;
    logic              stop_on_full;
    logic              trig_en;
    logic [XLEN-1:0]   trig_pc;
    logic [POST_W-1:0] post_cnt;
    logic              rd_req;
    logic              rd_valid;
    logic [XLEN-1:0]   rd_pc;
    logic [XLEN-1:0]   rd_instr;
    logic [3:0]        rd_flags;
    logic [XLEN-1:0]   rd_alu;
    logic [XLEN-1:0]   rd_addr;
    logic [XLEN-1:0]   rd_wdata;
    logic [TS_W-1:0]   rd_ts;
    logic [1:0]        state_o;
    logic [4:0]        count_o;
    logic              overflow;

    commit_trace_buffer #(
        .XLEN(XLEN), .DEPTH(DEPTH), .POST_W(POST_W), .TS_W(TS_W)
    ) dut (
        .clk(clk), .rst(rst), .cap_valid(cap_valid), .pc(pc), .instruction(instruction),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .ALU_Result(ALU_Result), .MemAddr(MemAddr), .MemWrite_Data(MemWrite_Data),
        .arm(arm), .stop_on_full(stop_on_full), .trig_en(trig_en), .trig_pc(trig_pc),
        .post_cnt(post_cnt), .rd_req(rd_req), .rd_valid(rd_valid), .rd_pc(rd_pc),
        .rd_instr(rd_instr), .rd_flags(rd_flags), .rd_alu(rd_alu), .rd_addr(rd_addr),
        .rd_wdata(rd_wdata), .rd_ts(rd_ts), .state_o(state_o), .count_o(count_o),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nTests = 0;
    int nFail  = 0;
    int tbCyc  = 0;

    // Cycle count since reset release, mirrors what a timestamp should hold.
    always @(posedge clk or negedge rst) begin
        if (!rst) tbCyc <= 0;
        else      tbCyc <= tbCyc + 1;
    end

    typedef struct {
        logic        arm;
        logic        cap;
        logic [31:0] pc;
        logic        trigEn;
        logic [31:0] trigPc;
        logic [7:0]  post;
        logic        sof;
        logic [1:0]  expState;
        int          expCount;
        logic        expOvf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] instrOf(input logic [31:0] p); return p ^ 32'hA5A5_0000; endfunction
    function automatic logic [31:0] aluOf(input logic [31:0] p);   return p + 32'h1000;      endfunction
    function automatic logic [31:0] addrOf(input logic [31:0] p);  return p + 32'h2000;      endfunction
    function automatic logic [31:0] wdataOf(input logic [31:0] p); return ~p;                endfunction

    task automatic driveCap(input logic v, input logic [31:0] p);
        cap_valid     = v;
        pc            = p;
        instruction   = instrOf(p);
        RegWrite      = p[2];
        MemRead       = p[3];
        MemWrite      = p[4];
        ALU_Result    = aluOf(p);
        MemAddr       = addrOf(p);
        MemWrite_Data = wdataOf(p);
    endtask

    task automatic addVec(input logic a, input logic c, input logic [31:0] p, input logic te,
                          input logic [31:0] tp, input logic [7:0] pcnt, input logic sof,
                          input logic [1:0] es, input int ec, input logic eo);
        vec_t v;
        v.arm = a; v.cap = c; v.pc = p; v.trigEn = te; v.trigPc = tp; v.post = pcnt;
        v.sof = sof; v.expState = es; v.expCount = ec; v.expOvf = eo;
        vecs.push_back(v);
    endtask

    task automatic runVecs(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            arm          = vecs[i].arm;
            trig_en      = vecs[i].trigEn;
            trig_pc      = vecs[i].trigPc;
            post_cnt     = vecs[i].post;
            stop_on_full = vecs[i].sof;
            driveCap(vecs[i].cap, vecs[i].pc);
            @(posedge clk); #1;
            check($sformatf("vec%0d state", i), 64'(state_o), 64'(vecs[i].expState));
            check($sformatf("vec%0d count", i), 64'(count_o), 64'(vecs[i].expCount));
            check($sformatf("vec%0d overflow", i), 64'(overflow), 64'(vecs[i].expOvf));
        end
        arm = 1'b0;
        cap_valid = 1'b0;
    endtask

    // Stream n entries with pc firstPc, firstPc+4, ...; then one request against an empty buffer.
    task automatic readStream(input string tag, input int n, input logic [31:0] firstPc,
                              input logic [31:0] trigAt);
        logic [31:0] p;
        rd_req = 1'b1;
        for (int i = 0; i < n; i++) begin
            p = firstPc + 32'(4 * i);
            @(posedge clk); #1;
            check($sformatf("%s rd_valid %0d", tag, i), 64'(rd_valid), 64'd1);
            check($sformatf("%s rd_pc %0d", tag, i), 64'(rd_pc), 64'(p));
            check($sformatf("%s rd_instr %0d", tag, i), 64'(rd_instr), 64'(instrOf(p)));
            check($sformatf("%s rd_flags %0d", tag, i), 64'(rd_flags),
                  64'({(p == trigAt), p[2], p[3], p[4]}));
            check($sformatf("%s rd_alu %0d", tag, i), 64'(rd_alu), 64'(aluOf(p)));
            check($sformatf("%s rd_addr %0d", tag, i), 64'(rd_addr), 64'(addrOf(p)));
            check($sformatf("%s rd_wdata %0d", tag, i), 64'(rd_wdata), 64'(wdataOf(p)));
        end
        @(posedge clk); #1;
        check({tag, " empty rd_valid"}, 64'(rd_valid), 64'd0);
        check({tag, " empty rd_pc hold"}, 64'(rd_pc), 64'(firstPc + 32'(4 * (n - 1))));
        check({tag, " empty count"}, 64'(count_o), 64'd0);
        rd_req = 1'b0;
    endtask

    int segA, segB, segC, segD, segE;

    initial begin
        rst = 1'b0; arm = 1'b0; rd_req = 1'b0; stop_on_full = 1'b0;
        trig_en = 1'b0; trig_pc = '0; post_cnt = '0;
        driveCap(1'b0, 32'h0);

        // Test 1: stop_on_full fill, then a dropped 17th capture freezes.
        addVec(1, 0, 32'h0, 0, 32'h0, 8'd0, 1, 2'd1, 0, 0);
        for (int i = 0; i < 16; i++) addVec(0, 1, 32'(4 * i), 0, 32'h0, 8'd0, 1, 2'd1, i + 1, 0);
        addVec(0, 1, 32'h40, 0, 32'h0, 8'd0, 1, 2'd3, 16, 0);
        addVec(0, 1, 32'h44, 0, 32'h0, 8'd0, 1, 2'd3, 16, 0);
        segA = vecs.size();
        // Test 2: wrap with overflow, trigger at 0x50 with two post entries.
        addVec(1, 0, 32'h0, 1, 32'h50, 8'd2, 0, 2'd1, 0, 0);
        for (int i = 0; i < 20; i++)
            addVec(0, 1, 32'(4 * i), 1, 32'h50, 8'd2, 0, 2'd1, (i < 16) ? i + 1 : 16, (i >= 16));
        addVec(0, 1, 32'h50, 1, 32'h50, 8'd2, 0, 2'd2, 16, 1);
        addVec(0, 1, 32'h54, 1, 32'h50, 8'd2, 0, 2'd2, 16, 1);
        addVec(0, 1, 32'h58, 1, 32'h50, 8'd2, 0, 2'd3, 16, 1);
        addVec(0, 1, 32'h5C, 1, 32'h5C, 8'd2, 0, 2'd3, 16, 1);
        segB = vecs.size();
        // Test 3: trigger on first capture with post_cnt 0.
        addVec(1, 0, 32'h0, 1, 32'h100, 8'd0, 0, 2'd1, 0, 0);
        addVec(0, 1, 32'h100, 1, 32'h100, 8'd0, 0, 2'd3, 1, 0);
        segC = vecs.size();
        // Test 4 setup: frozen with one entry.
        addVec(1, 0, 32'h0, 1, 32'h100, 8'd0, 0, 2'd1, 0, 0);
        addVec(0, 1, 32'h100, 1, 32'h100, 8'd0, 0, 2'd3, 1, 0);
        segD = vecs.size();
        // Test 5 setup: into POST with three entries pending.
        addVec(1, 0, 32'h0, 1, 32'h200, 8'd3, 0, 2'd1, 0, 0);
        addVec(0, 1, 32'h1FC, 1, 32'h200, 8'd3, 0, 2'd1, 1, 0);
        addVec(0, 1, 32'h200, 1, 32'h200, 8'd3, 0, 2'd2, 2, 0);
        segE = vecs.size();

        #12 rst = 1'b1;
        @(negedge clk);
        check("reset state", 64'(state_o), 64'd0);
        check("reset count", 64'(count_o), 64'd0);
        check("reset overflow", 64'(overflow), 64'd0);
        check("reset rd_valid", 64'(rd_valid), 64'd0);
        check("reset rd_pc", 64'(rd_pc), 64'd0);

        // IDLE ignores captures.
        driveCap(1'b1, 32'h8);
        @(posedge clk); #1;
        check("idle no capture", 64'(count_o), 64'd0);
        check("idle state", 64'(state_o), 64'd0);
        cap_valid = 1'b0;

        runVecs(0, segA);
        readStream("t1", 16, 32'h0, 32'hFFFF_FFFF);

        runVecs(segA, segB);
        readStream("t2", 16, 32'h1C, 32'h50);

        runVecs(segB, segC);
        readStream("t3", 1, 32'h100, 32'h100);

        runVecs(segC, segD);
        arm = 1'b1; rd_req = 1'b1;
        @(posedge clk); #1;
        check("t4 state", 64'(state_o), 64'd1);
        check("t4 count", 64'(count_o), 64'd0);
        check("t4 rd_valid", 64'(rd_valid), 64'd0);
        arm = 1'b0;
        @(posedge clk); #1;
        check("t4 rd ignored in ARMED", 64'(rd_valid), 64'd0);
        rd_req = 1'b0;

        runVecs(segD, segE);
        #2 rst = 1'b0;
        #1;
        check("t5 state", 64'(state_o), 64'd0);
        check("t5 count", 64'(count_o), 64'd0);
        check("t5 overflow", 64'(overflow), 64'd0);
        check("t5 rd_valid", 64'(rd_valid), 64'd0);
        check("t5 rd_pc", 64'(rd_pc), 64'd0);
        @(negedge clk);
        rst = 1'b1;

`ifdef TRACE_TIMESTAMP_EN
        begin
            int ts1, ts2, guard;
            trig_en = 1'b0; post_cnt = '0; stop_on_full = 1'b0;
            arm = 1'b1;
            @(posedge clk); #1;
            arm = 1'b0;
            guard = 0;
            while (tbCyc != 5 && guard < 50) begin @(posedge clk); #1; guard++; end
            check("t6 wait 5", 64'(tbCyc), 64'd5);
            driveCap(1'b1, 32'h300); ts1 = tbCyc;
            @(posedge clk); #1;
            cap_valid = 1'b0;
            guard = 0;
            while (tbCyc != 9 && guard < 50) begin @(posedge clk); #1; guard++; end
            check("t6 wait 9", 64'(tbCyc), 64'd9);
            trig_en = 1'b1; trig_pc = 32'h304;
            driveCap(1'b1, 32'h304); ts2 = tbCyc;
            @(posedge clk); #1;
            cap_valid = 1'b0; trig_en = 1'b0;
            check("t6 state", 64'(state_o), 64'd3);
            check("t6 count", 64'(count_o), 64'd2);
            rd_req = 1'b1;
            @(posedge clk); #1;
            check("t6 ts first", 64'(rd_ts), 64'(ts1));
            @(posedge clk); #1;
            check("t6 ts second", 64'(rd_ts), 64'(ts2));
            rd_req = 1'b0;
        end
`else
        check("rd_ts tied low", 64'(rd_ts), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
